// File: rtl/ibex_mem_port_arbiter.sv
// Arbitrates the Ibex instruction-fetch and load/store hosts onto one memory port.
// Data wins by default; a starvation counter forces an instr win, and an ID FIFO routes responses back.
module ibex_mem_port_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,

  output logic [31:0] rsp_rdata_o,
  output logic [6:0]  rsp_rdata_intg_o,
  output logic        rsp_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [6:0]  mem_wdata_intg_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [6:0]  mem_rdata_intg_i,
  input  logic        mem_err_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned StW  = $clog2(StarveLimit + 1);

  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [StW-1:0]  StMax   = StW'(StarveLimit);

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_e;

  host_e           sel;
  host_e           lock_sel_q, lock_sel_d;
  logic            lock_valid_q, lock_valid_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  host_e           id_q [MaxOutstanding];
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    sel = HostData;
    if (lock_valid_q) begin
      sel = lock_sel_q;
    end else if (instr_req_i && (!data_req_i || starve_q == StMax)) begin
      sel = HostInstr;
    end
  end

  // Gated by rst_ni so no request or grant leaks out while reset is held.
  assign mem_req_o        = rst_ni & (instr_req_i | data_req_i) & (count_q < CntMax);
  assign mem_we_o         = (sel == HostData) ? data_we_i   : 1'b0;
  assign mem_be_o         = (sel == HostData) ? data_be_i   : 4'hF;
  assign mem_addr_o       = (sel == HostData) ? data_addr_i : instr_addr_i;
  assign mem_wdata_o      = data_wdata_i;
  assign mem_wdata_intg_o = data_wdata_intg_i;

  assign push        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & (sel == HostInstr);
  assign data_gnt_o  = push & (sel == HostData);

  // Responses with nothing outstanding are dropped rather than underflowing the FIFO.
  assign pop            = mem_rvalid_i & (count_q != '0);
  assign instr_rvalid_o = pop & (id_q[rd_ptr_q] == HostInstr);
  assign data_rvalid_o  = pop & (id_q[rd_ptr_q] == HostData);

  assign rsp_rdata_o      = mem_rdata_i;
  assign rsp_rdata_intg_o = mem_rdata_intg_i;
  assign rsp_err_o        = mem_err_i;

  always_comb begin
    lock_valid_d = mem_req_o & ~mem_gnt_i;
    lock_sel_d   = sel;

    starve_d = starve_q;
    if (instr_gnt_o) begin
      starve_d = '0;
    end else if (instr_req_i && starve_q != StMax) begin
      starve_d = starve_q + 1'b1;
    end

    count_d  = count_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_sel_q   <= HostData;
      starve_q     <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_sel_q   <= lock_sel_d;
      starve_q     <= starve_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: the ID storage is not reset; count_q gates every read, so stale entries are never used.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr_q] <= sel;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> (count_q != '0))
    else $warning("mem_rvalid_i with no outstanding transaction; response dropped");

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Self-checking bench for ibex_mem_port_arbiter: per-cycle grant expectations plus a
// scoreboard of expected response hosts, pushed at grant and popped on each mem_rvalid_i.
module tb_ibex_mem_port_arbiter;

  localparam logic [31:0] IAddr  = 32'h0000_1000;
  localparam logic [31:0] DAddr  = 32'h8000_2040;
  localparam logic [31:0] DWdata = 32'hCAFE_F00D;
  localparam logic [6:0]  DWintg = 7'h55;
  localparam logic [3:0]  DBe    = 4'h3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = IAddr;
  logic        instr_gnt_o, instr_rvalid_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b1;
  logic [3:0]  data_be_i = DBe;
  logic [31:0] data_addr_i = DAddr;
  logic [31:0] data_wdata_i = DWdata;
  logic [6:0]  data_wdata_intg_i = DWintg;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] rsp_rdata_o;
  logic [6:0]  rsp_rdata_intg_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [6:0]  mem_wdata_intg_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [6:0]  mem_rdata_intg_i = '0;
  logic        mem_err_i = 1'b0;

  ibex_mem_port_arbiter #(.MaxOutstanding(2), .StarveLimit(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_wdata_intg_i(data_wdata_intg_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_rdata_intg_o(rsp_rdata_intg_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rdata_intg_i(mem_rdata_intg_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q [$];  // expected response host: 0 = instr, 1 = data

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check 1ns later, state commits at the following posedge.
  // exp_sel: 0 = instr, 1 = data; exp_g: the selected host is granted this cycle.
  task automatic cyc(input string tag, input logic ireq, input logic dreq, input logic gnt,
                     input logic rv, input logic err,
                     input logic exp_req, input logic exp_sel, input logic exp_g);
    logic [31:0] rd;
    logic [6:0]  ri;
    logic [1:0]  exp_rv;
    logic [1:0]  exp_gnt;
    @(negedge clk_i);
    rd = $urandom;
    ri = 7'($urandom);
    instr_req_i = ireq; data_req_i = dreq; mem_gnt_i = gnt;
    mem_rvalid_i = rv; mem_err_i = err; mem_rdata_i = rd; mem_rdata_intg_i = ri;
    #1;
    check({tag, ".req"}, 32'(mem_req_o), 32'(exp_req));
    exp_gnt = exp_g ? (exp_sel ? 2'b01 : 2'b10) : 2'b00;
    check({tag, ".gnt"}, 32'({instr_gnt_o, data_gnt_o}), 32'(exp_gnt));
    check({tag, ".wdata"}, mem_wdata_o, DWdata);
    if (exp_req) begin
      check({tag, ".addr"}, mem_addr_o, exp_sel ? DAddr : IAddr);
      check({tag, ".be"}, 32'(mem_be_o), exp_sel ? 32'(DBe) : 32'hF);
      check({tag, ".we"}, 32'(mem_we_o), 32'(exp_sel));
    end
    exp_rv = 2'b00;
    if (rv && exp_q.size() > 0) exp_rv = exp_q.pop_front() ? 2'b01 : 2'b10;
    check({tag, ".rvalid"}, 32'({instr_rvalid_o, data_rvalid_o}), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      check({tag, ".rdata"}, rsp_rdata_o, rd);
      check({tag, ".rintg"}, 32'(rsp_rdata_intg_o), 32'(ri));
      check({tag, ".err"}, 32'(rsp_err_o), 32'(err));
    end
    if (exp_g) exp_q.push_back(exp_sel);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_ni = 1'b0;
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    check({tag, ".rst_req"}, 32'(mem_req_o), 32'h0);
    check({tag, ".rst_gnt"}, 32'({instr_gnt_o, data_gnt_o}), 32'h0);
    check({tag, ".rst_rvalid"}, 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
    repeat (2) @(negedge clk_i);
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    rst_ni = 1'b1;
    exp_q.delete();  // anything in flight is dropped by reset
  endtask

  initial begin
    // Starvation: data wins 4 cycles, instr the 5th, then the counter is clear again.
    do_reset("starve");
    cyc("starve.c1", 1, 1, 1, 0, 0, 1, 1, 1);
    cyc("starve.c2", 1, 1, 1, 1, 0, 1, 1, 1);
    cyc("starve.c3", 1, 1, 1, 1, 0, 1, 1, 1);
    cyc("starve.c4", 1, 1, 1, 1, 0, 1, 1, 1);
    cyc("starve.c5", 1, 1, 1, 1, 0, 1, 0, 1);
    cyc("starve.c6", 1, 1, 1, 1, 0, 1, 1, 1);
    cyc("starve.c7", 0, 0, 0, 1, 0, 0, 0, 0);

    // Lock: instr stalled 3 cycles, data arrives meanwhile; then in-order responses with err.
    do_reset("lock");
    cyc("lock.c1", 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("lock.c2", 1, 1, 0, 0, 0, 1, 0, 0);
    cyc("lock.c3", 1, 1, 0, 0, 0, 1, 0, 0);
    cyc("lock.c4", 1, 1, 1, 0, 0, 1, 0, 1);
    cyc("lock.c5", 0, 1, 1, 0, 0, 1, 1, 1);
    cyc("rsp.c1",  0, 0, 0, 1, 0, 0, 0, 0);
    cyc("rsp.c2",  0, 0, 0, 1, 1, 0, 0, 0);

    // Outstanding limit: full blocks even with a same-cycle pop; push+pop keeps occupancy.
    do_reset("full");
    cyc("full.c1", 0, 1, 1, 0, 0, 1, 1, 1);
    cyc("full.c2", 0, 1, 1, 0, 0, 1, 1, 1);
    cyc("full.c3", 0, 1, 1, 0, 0, 0, 1, 0);
    cyc("full.c4", 0, 1, 1, 1, 0, 0, 1, 0);
    cyc("full.c5", 0, 1, 1, 1, 0, 1, 1, 1);
    cyc("full.c6", 0, 1, 1, 0, 0, 1, 1, 1);
    cyc("full.c7", 0, 1, 1, 0, 0, 0, 1, 0);
    cyc("full.c8", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("full.c9", 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset with two outstanding: late responses are dropped and occupancy restarts at 0.
    do_reset("drop");
    cyc("drop.c1", 1, 0, 1, 0, 0, 1, 0, 1);
    cyc("drop.c2", 0, 1, 1, 0, 0, 1, 1, 1);
    do_reset("drop");
    cyc("drop.rv1", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("drop.rv2", 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    check("drop.count", 32'(dut.count_q), 32'h0);
    cyc("drop.c3", 0, 1, 1, 0, 0, 1, 1, 1);
    cyc("drop.c4", 0, 1, 1, 0, 0, 1, 1, 1);
    cyc("drop.c5", 0, 1, 1, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
